scsa_window_gen: RTL and testbench



---
 rtl/scsa_window_gen.sv | 138 +++++++++++++
 tb/tb_scsa_window_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scsa_window_gen.sv
// Speculative window stage of the carry-select adder: per-4-bit-window sums for
// carry-in 0 and 1 plus speculative select bits, behind a 2-stage valid/ready pipe.
// Optional build macro SCSA_ERR_DETECT_EN adds err / err_cnt misspeculation reporting.
module scsa_window_gen #(
    parameter  int WIDTH = 16,
    localparam int NWIN  = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum0,
    output logic [WIDTH-1:0] sum1,
    output logic [NWIN-1:0]  sel,
`ifdef SCSA_ERR_DETECT_EN
    output logic             err,
    output logic [15:0]      err_cnt,
`endif
    output logic             cout
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_adv;
    logic             s2_adv;

    logic [WIDTH-1:0] sum0_d;
    logic [WIDTH-1:0] sum1_d;
    logic [NWIN-1:0]  carry0;
    logic [NWIN-1:0]  sel_d;
    logic [4:0]       win0;
    logic [4:0]       win1;

    // Stages advance when their contents can move on (or they are empty).
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Each window uses only its own operand nibbles; no carry crosses a window boundary.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        sum0_d = '0;
        sum1_d = '0;
        carry0 = '0;
        sel_d  = '0;
        win0   = '0;
        win1   = '0;
        for (int k = 0; k < NWIN; k++) begin
            win0 = {1'b0, s1_a[4*k +: 4]} + {1'b0, s1_b[4*k +: 4]};
            win1 = win0 + 5'd1;
            sum0_d[4*k +: 4] = win0[3:0];
            sum1_d[4*k +: 4] = win1[3:0];
            carry0[k]        = win0[4];
        end
        for (int k = 1; k < NWIN; k++) begin
            sel_d[k] = carry0[k-1];
        end
    end

`ifdef SCSA_ERR_DETECT_EN
    logic            err_d;
    logic            ripple;
    logic [NWIN-1:0] exact_cin;
    logic [4:0]      ex0;

    // Exact ripple carry into each window, to flag where speculation was wrong.
    always_comb begin
        err_d     = 1'b0;
        ripple    = 1'b0;
        exact_cin = '0;
        ex0       = '0;
        for (int k = 0; k < NWIN; k++) begin
            exact_cin[k] = ripple;
            ex0    = {1'b0, s1_a[4*k +: 4]} + {1'b0, s1_b[4*k +: 4]} + {4'b0, ripple};
            ripple = ex0[4];
        end
        for (int k = 1; k < NWIN; k++) begin
            if (sel_d[k] != exact_cin[k]) err_d = 1'b1;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a <= a;
                s1_b <= b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum0      <= '0;
            sum1      <= '0;
            sel       <= '0;
            cout      <= 1'b0;
`ifdef SCSA_ERR_DETECT_EN
            err       <= 1'b0;
`endif
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum0 <= sum0_d;
                sum1 <= sum1_d;
                sel  <= sel_d;
                cout <= carry0[NWIN-1];
`ifdef SCSA_ERR_DETECT_EN
                err  <= err_d;
`endif
            end
        end
    end

`ifdef SCSA_ERR_DETECT_EN
    // Counts only results actually taken downstream; saturates rather than wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scsa_window_gen.sv
// Self-checking bench for scsa_window_gen (WIDTH=16) using an expected-result
// queue filled on accept and drained on output handshake.
module tb_scsa_window_gen;

    typedef struct packed {
        logic [15:0] sum0;
        logic [15:0] sum1;
        logic [3:0]  sel;
        logic        cout;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum0;
    logic [15:0] sum1;
    logic [3:0]  sel;
    logic        cout;
`ifdef SCSA_ERR_DETECT_EN
    logic        err;
    logic [15:0] err_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    scsa_window_gen #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum0      (sum0),
        .sum1      (sum1),
        .sel       (sel),
`ifdef SCSA_ERR_DETECT_EN
        .err       (err),
        .err_cnt   (err_cnt),
`endif
        .cout      (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: nibble arithmetic for window sums, full-width addition for exact carries.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb);
        exp_t r;
        int   s;
        int   lowmask;
        int   full;
        logic [3:0] c0;
        r  = '0;
        c0 = '0;
        for (int k = 0; k < 4; k++) begin
            s = int'((ma >> (4*k)) & 16'hF) + int'((mb >> (4*k)) & 16'hF);
            r.sum0[4*k +: 4] = 4'(s % 16);
            r.sum1[4*k +: 4] = 4'((s + 1) % 16);
            c0[k] = (s >= 16);
        end
        r.sel  = {c0[2:0], 1'b0};
        r.cout = c0[3];
        for (int k = 1; k < 4; k++) begin
            lowmask = (1 << (4*k)) - 1;
            full    = (int'(ma) & lowmask) + (int'(mb) & lowmask);
            if (r.sel[k] != full[4*k]) r.err = 1'b1;
        end
        return r;
    endfunction

    // Offer one operand pair; record the expectation on the cycle it is accepted.
    task automatic drive(input logic [15:0] da, input logic [15:0] db, input exp_t e);
        bit done = 0;
        in_valid = 1'b1;
        a        = da;
        b        = db;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1;
            end
        end
        if (!done) check("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    // Compare every result the DUT hands off against the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("stale_result", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("sum0", sum0, e.sum0);
                    check("sum1", sum1, e.sum1);
                    check("sel", sel, e.sel);
                    check("cout", cout, e.cout);
`ifdef SCSA_ERR_DETECT_EN
                    check("err", err, e.err);
`endif
                end
            end
        end
    end

    initial begin
        exp_t p0;
        p0        = model(16'h00FF, 16'h0001);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum0", sum0, 0);
        check("rst_sum1", sum1, 0);
        check("rst_sel", sel, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
`ifdef SCSA_ERR_DETECT_EN
        check("rst_err_cnt", err_cnt, 0);
`endif

        // Latency: accepted at edge N, valid after edge N+1.
        out_ready = 1'b1;
        drive(16'h1234, 16'h1111, '{16'h2345, 16'h3456, 4'b0000, 1'b0, 1'b0});
        in_valid = 1'b0;
        check("lat_edge_n", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_edge_n1", out_valid, 1);

        // Directed vectors back to back at full rate.
        drive(16'hFFFF, 16'h0001, '{16'hFFF0, 16'h0001, 4'b0010, 1'b0, 1'b1});
        drive(16'h00FF, 16'h0001, '{16'h00F0, 16'h1101, 4'b0010, 1'b0, 1'b1});
        drive(16'hF000, 16'h1000, '{16'h0000, 16'h1111, 4'b0000, 1'b1, 1'b0});
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("drain_out_valid", out_valid, 0);
        check("drain_empty", sb.size(), 0);
`ifdef SCSA_ERR_DETECT_EN
        check("err_cnt_directed", err_cnt, 2);
`endif

        // Backpressure: two stages fill, third offer stalls, outputs hold.
        out_ready = 1'b0;
        drive(16'h00FF, 16'h0001, p0);
        drive(16'h1234, 16'h4321, model(16'h1234, 16'h4321));
        in_valid = 1'b1;
        a        = 16'h0FFF;
        b        = 16'h0001;
        check("bp_in_ready_low", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_sum0", sum0, p0.sum0);
            check("bp_hold_sum1", sum1, p0.sum1);
            check("bp_hold_sel", sel, p0.sel);
        end
`ifdef SCSA_ERR_DETECT_EN
        check("bp_err_cnt_hold", err_cnt, 2);
`endif
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        sb.push_back(model(16'h0FFF, 16'h0001));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_stream0", out_valid, 1);
        @(posedge clk);
        #1;
        check("bp_stream1", out_valid, 1);
        @(posedge clk);
        #1;
        check("bp_stream_end", out_valid, 0);
        check("bp_drained", sb.size(), 0);
`ifdef SCSA_ERR_DETECT_EN
        check("bp_err_cnt", err_cnt, 4);
`endif

        // Reset with two results in flight.
        out_ready = 1'b0;
        drive(16'h0F0F, 16'h0101, model(16'h0F0F, 16'h0101));
        drive(16'hFFFF, 16'h0001, model(16'hFFFF, 16'h0001));
        in_valid = 1'b0;
        check("mid_full_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sum0", sum0, 0);
        check("mid_rst_sum1", sum1, 0);
        check("mid_rst_sel", sel, 0);
        check("mid_rst_cout", cout, 0);
`ifdef SCSA_ERR_DETECT_EN
        check("mid_rst_err_cnt", err_cnt, 0);
`endif
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("no_stale_valid", out_valid, 0);
        end
        check("post_rst_in_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
